// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
//   Shared constants for the input conditioner: encoder FSM state
//   encodings, colour-index codes and the lowest-set-colour helper.
//   No ports.
package input_conditioner_pkg;

    localparam int NUM_COLOURS = 4;

    typedef logic [1:0] enc_state_t;
    typedef logic [1:0] colour_t;

    // Encoder FSM states. Encoding 2'd3 is unused.
    localparam enc_state_t ENC_IDLE    = 2'd0;
    localparam enc_state_t ENC_HELD    = 2'd1;
    localparam enc_state_t ENC_BLOCKED = 2'd2;

    // Colour-index codes: BTN bit k encodes as colour k.
    localparam colour_t COLOUR_0 = 2'd0;
    localparam colour_t COLOUR_1 = 2'd1;
    localparam colour_t COLOUR_2 = 2'd2;
    localparam colour_t COLOUR_3 = 2'd3;

    // Index of the lowest set bit. Returns COLOUR_0 when none are set;
    // callers only use the result when at least one bit is set.
    function automatic colour_t lowest_colour(input logic [NUM_COLOURS-1:0] bits);
        colour_t idx;
        idx = COLOUR_0;
        for (int i = NUM_COLOURS - 1; i >= 0; i--) begin
            if (bits[i]) idx = colour_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/debounce.sv
// debounce
//   Two-flop synchroniser followed by a stable-run counter. The
//   debounced level toggles only after the synchronised input has
//   differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   raw    in   raw asynchronous input
//   level  out  debounced level
module debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // The counter tops out at DEBOUNCE_CYCLES-1: the step that would
    // reach DEBOUNCE_CYCLES toggles the level and clears instead.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
//   Debounces four colour buttons and a start button, then encodes the
//   first accepted colour press into a 2-bit code with a valid flag.
// Ports
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset (externally synchronised release)
//   BTN[3:0]    in   raw colour buttons, active-high, bit k = colour k
//   BTN_START   in   raw start button, active-high
//   IN[1:0]     out  colour code of the accepted press (held in IDLE/BLOCKED)
//   IN_VALID    out  high while the accepted colour is held
//   START_GAME  out  debounced start level, one register stage later
//
// Encoder FSM
//   state   | meaning
//   IDLE    | waiting for any debounced colour press
//   HELD    | colour latched in IN, IN_VALID high
//   BLOCKED | latched colour released while another is still down; wait for all clear
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] BTN,
    input  logic       BTN_START,
    output logic [1:0] IN,
    output logic       IN_VALID,
    output logic       START_GAME
);

    logic [NUM_COLOURS-1:0] colour_deb;
    logic                   start_deb;
    enc_state_t             state;
    enc_state_t             state_nxt;
    colour_t                in_nxt;

    for (genvar k = 0; k < NUM_COLOURS; k++) begin : g_colour_db
        debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .CLK   (CLK),
            .RST_N (RST_N),
            .raw   (BTN[k]),
            .level (colour_deb[k])
        );
    end

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (BTN_START),
        .level (start_deb)
    );

    always_comb begin
        state_nxt = state;
        in_nxt    = IN;
        case (state)
            ENC_IDLE: begin
                if (|colour_deb) begin
                    state_nxt = ENC_HELD;
                    in_nxt    = lowest_colour(colour_deb);
                end
            end
            ENC_HELD: begin
                if (!colour_deb[IN]) begin
                    state_nxt = (|colour_deb) ? ENC_BLOCKED : ENC_IDLE;
                end
            end
            ENC_BLOCKED: begin
                if (colour_deb == '0) state_nxt = ENC_IDLE;
            end
            default: state_nxt = ENC_IDLE;
        endcase
    end

    // IN_VALID is registered from the next state so it rises on the
    // same edge that enters HELD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ENC_IDLE;
            IN         <= COLOUR_0;
            IN_VALID   <= 1'b0;
            START_GAME <= 1'b0;
        end else begin
            state      <= state_nxt;
            IN         <= in_nxt;
            IN_VALID   <= (state_nxt == ENC_HELD);
            START_GAME <= start_deb;
        end
    end

endmodule
